// File: rtl/alu_ctrl_seq.sv
// alu_ctrl_seq: registered EX-stage ALU control decode with a countdown sequencer for shared mult/div HI/LO
module alu_ctrl_seq #(
  parameter int CTRL_W = 4,
  parameter int MUL_CYCLES = 4,
  parameter int DIV_CYCLES = 32,
  parameter int CNT_W = 6
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              valid_in,
  input  logic [2:0]        alu_op,
  input  logic [5:0]        func,
  input  logic              ex_stall,
  input  logic              flush,
  output logic [CTRL_W-1:0] alu_ctr,
  output logic              ctr_valid,
  output logic              illegal,
  output logic [1:0]        hilo_rd,
  output logic              md_start,
  output logic [1:0]        md_sel,
  output logic              md_busy,
  output logic              hilo_we,
  output logic              stall_req
);
  typedef enum logic {IDLE, RUN} state_t;
  localparam logic [3:0] C_AND = 4'd0, C_OR = 4'd1, C_ADD = 4'd2, C_XOR = 4'd3,
    C_NOR = 4'd4, C_SLL = 4'd5, C_SUB = 4'd6, C_SLT = 4'd7, C_SLTU = 4'd8,
    C_SRL = 4'd9, C_SRA = 4'd10, C_PASS = 4'd11;
  state_t state, state_nx;
  logic [CNT_W-1:0] cnt, cnt_nx;
  logic [3:0] code;
  logic bad, is_hi, is_lo, is_md, hazard, accept, launch, done;
  always_comb begin
    code = C_ADD;
    bad = 1'b0;
    is_hi = 1'b0;
    is_lo = 1'b0;
    is_md = 1'b0;
    case (alu_op)
      3'b001: code = C_SUB;
      3'b010: code = C_AND;
      3'b011: code = C_OR;
      3'b101: code = C_SLT;
      3'b110: code = C_PASS;
      3'b111: code = C_XOR;
      3'b100:
        case (func)
          6'b100000, 6'b100001: code = C_ADD;
          6'b100010, 6'b100011: code = C_SUB;
          6'b100100: code = C_AND;
          6'b100101: code = C_OR;
          6'b100110: code = C_XOR;
          6'b100111: code = C_NOR;
          6'b101010: code = C_SLT;
          6'b101011: code = C_SLTU;
          6'b000000: code = C_SLL;
          6'b000010: code = C_SRL;
          6'b000011: code = C_SRA;
          6'b010000: begin
            code = C_PASS;
            is_hi = 1'b1;
          end
          6'b010010: begin
            code = C_PASS;
            is_lo = 1'b1;
          end
          6'b011000, 6'b011001, 6'b011010, 6'b011011: is_md = 1'b1;
          default: bad = 1'b1;
        endcase
      default: code = C_ADD;
    endcase
  end
  assign md_busy = (state == RUN);
  assign hazard = valid_in & (is_hi | is_lo | is_md) & md_busy;
  assign stall_req = hazard;
  assign accept = valid_in & ~ex_stall & ~flush & ~hazard;
  // hazard blocks md ops while busy, so a launch always comes from IDLE
  assign launch = accept & is_md;
  assign done = md_busy & (cnt == '0);
  always_comb begin
    state_nx = state;
    cnt_nx = cnt;
    if (state == IDLE) begin
      if (launch) begin
        state_nx = RUN;
        cnt_nx = func[1] ? CNT_W'(DIV_CYCLES - 1) : CNT_W'(MUL_CYCLES - 1);
      end
    end else if (done)
      state_nx = IDLE;
    else
      cnt_nx = cnt - 1'b1;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      cnt <= '0;
      alu_ctr <= CTRL_W'(C_ADD);
      ctr_valid <= 1'b0;
      illegal <= 1'b0;
      hilo_rd <= 2'b00;
      md_sel <= 2'b00;
      md_start <= 1'b0;
      hilo_we <= 1'b0;
    end else begin
      state <= state_nx;
      cnt <= cnt_nx;
      md_start <= launch;
      hilo_we <= done;
      if (!ex_stall) begin
        ctr_valid <= accept;
        alu_ctr <= accept ? CTRL_W'(code) : CTRL_W'(C_ADD);
        illegal <= accept & bad;
        hilo_rd <= accept ? {is_hi, is_lo} : 2'b00;
        if (launch) md_sel <= func[1:0];
      end
    end
  end
endmodule

// File: tb/tb_alu_ctrl_seq.sv
// tb_alu_ctrl_seq: directed bench with an expected-result queue for the decoded control word
module tb_alu_ctrl_seq;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic valid_in = 1'b0, ex_stall = 1'b0, flush = 1'b0;
  logic [2:0] alu_op = 3'b000;
  logic [5:0] func = 6'b000000;
  logic [3:0] alu_ctr;
  logic ctr_valid, illegal, md_start, md_busy, hilo_we, stall_req;
  logic [1:0] hilo_rd, md_sel;
  typedef struct packed {logic [3:0] ctr; logic ill; logic [1:0] rd;} exp_t;
  exp_t q[$];
  int vec = 0, errs = 0;
  int cyc_n = 0, busy_n = 0, start_n = 0, we_n = 0, we_at = 0;
  int base, b0, s0, w0, stalls, k;
  logic [5:0] r_fn [16] = '{6'b100000, 6'b100001, 6'b100010, 6'b100011, 6'b100100, 6'b100101,
    6'b100110, 6'b100111, 6'b101010, 6'b101011, 6'b000000, 6'b000010, 6'b000011, 6'b010000,
    6'b010010, 6'b000001};
  int r_code [16] = '{2, 2, 6, 6, 0, 1, 3, 4, 7, 8, 5, 9, 10, 11, 11, 2};
  logic [1:0] r_rd [16] = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 2'b10, 2'b01, 0};
  logic [2:0] n_op [7] = '{3'b000, 3'b001, 3'b010, 3'b011, 3'b101, 3'b110, 3'b111};
  int n_code [7] = '{2, 6, 0, 1, 7, 11, 3};

  alu_ctrl_seq dut (
    .clk(clk), .rst(rst), .valid_in(valid_in), .alu_op(alu_op), .func(func),
    .ex_stall(ex_stall), .flush(flush), .alu_ctr(alu_ctr), .ctr_valid(ctr_valid),
    .illegal(illegal), .hilo_rd(hilo_rd), .md_start(md_start), .md_sel(md_sel),
    .md_busy(md_busy), .hilo_we(hilo_we), .stall_req(stall_req)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    cyc_n++;
    busy_n += int'(md_busy);
    start_n += int'(md_start);
    if (hilo_we) begin
      we_n++;
      we_at = cyc_n;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vec++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: got %0d want %0d", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [2:0] op, input logic [5:0] fn, input int ctr,
                       input logic ill, input logic [1:0] rd);
    valid_in = 1'b1;
    alu_op = op;
    func = fn;
    q.push_back('{4'(ctr), ill, rd});
  endtask

  task automatic take(input string tag);
    exp_t e;
    chk({tag, " ctr_valid"}, ctr_valid, 1);
    chk({tag, " sb depth"}, q.size(), 1);
    if (q.size() != 0) begin
      e = q.pop_front();
      chk({tag, " alu_ctr"}, alu_ctr, e.ctr);
      chk({tag, " illegal"}, illegal, e.ill);
      chk({tag, " hilo_rd"}, hilo_rd, e.rd);
    end
  endtask

  task automatic wait_we(input int from);
    int n = 0;
    while (we_at <= from && n < 200) begin
      cyc();
      n++;
    end
    chk("hilo_we seen", we_at > from, 1);
  endtask

  task automatic snap();
    base = cyc_n;
    b0 = busy_n;
    s0 = start_n;
    w0 = we_n;
  endtask

  initial begin
    repeat (2) cyc();
    chk("rst alu_ctr", alu_ctr, 2);
    chk("rst ctr_valid", ctr_valid, 0);
    chk("rst illegal", illegal, 0);
    chk("rst hilo_rd", hilo_rd, 0);
    chk("rst md_busy", md_busy, 0);
    chk("rst md_start", md_start, 0);
    chk("rst hilo_we", hilo_we, 0);
    chk("rst md_sel", md_sel, 0);
    rst = 1'b0;
    cyc();
    for (int i = 0; i < 16; i++) begin
      issue(3'b100, r_fn[i], r_code[i], i == 15, r_rd[i]);
      cyc();
      take($sformatf("rtype %0d", i));
    end
    for (int i = 0; i < 7; i++) begin
      issue(n_op[i], 6'b011000, n_code[i], 1'b0, 2'b00);
      cyc();
      take($sformatf("aluop %0d", i));
      chk("aluop no md_start", md_start, 0);
    end
    valid_in = 1'b0;
    cyc();
    chk("idle bubble", ctr_valid, 0);

    issue(3'b100, 6'b011000, 2, 1'b0, 2'b00);
    cyc();
    take("mult");
    chk("mult md_start", md_start, 1);
    chk("mult md_busy", md_busy, 1);
    chk("mult md_sel", md_sel, 0);
    snap();
    valid_in = 1'b0;
    wait_we(base);
    chk("mult busy cycles", busy_n - b0, 4);
    chk("mult starts", start_n - s0, 1);
    chk("mult hilo_we cycle", we_at - base, 5);

    issue(3'b100, 6'b011010, 2, 1'b0, 2'b00);
    cyc();
    take("div");
    chk("div md_sel", md_sel, 2);
    valid_in = 1'b1;
    alu_op = 3'b100;
    func = 6'b010010;
    stalls = 0;
    k = 0;
    while (k < 200) begin
      #1;
      if (!stall_req) break;
      stalls++;
      cyc();
      k++;
    end
    chk("mflo stall cycles", stalls, 32);
    chk("mflo in hilo_we cycle", hilo_we, 1);
    chk("mflo bubble", ctr_valid, 0);
    issue(3'b100, 6'b010010, 11, 1'b0, 2'b01);
    cyc();
    take("mflo");
    valid_in = 1'b0;
    cyc();

    issue(3'b100, 6'b011010, 2, 1'b0, 2'b00);
    cyc();
    take("div2");
    snap();
    issue(3'b000, 6'b010000, 2, 1'b0, 2'b00);
    #1;
    chk("add no stall", stall_req, 0);
    cyc();
    take("add in run");
    chk("busy during add", md_busy, 1);
    issue(3'b011, 6'b011001, 1, 1'b0, 2'b00);
    cyc();
    take("or in run");
    chk("or no md_start", md_start, 0);
    valid_in = 1'b0;
    wait_we(base);
    chk("div busy cycles", busy_n - b0, 32);
    chk("div hilo_we cycle", we_at - base, 33);

    issue(3'b100, 6'b011000, 2, 1'b0, 2'b00);
    cyc();
    take("mult2");
    snap();
    ex_stall = 1'b1;
    valid_in = 1'b1;
    alu_op = 3'b001;
    func = 6'b000000;
    for (int i = 0; i < 3; i++) begin
      cyc();
      chk("frozen ctr_valid", ctr_valid, 1);
      chk("frozen alu_ctr", alu_ctr, 2);
      chk("frozen md_start", md_start, 0);
    end
    ex_stall = 1'b0;
    valid_in = 1'b0;
    wait_we(base);
    chk("stalled mult busy", busy_n - b0, 4);
    chk("stalled mult starts", start_n - s0, 1);
    chk("stalled mult hilo_we", we_at - base, 5);
    chk("sb drained", q.size(), 0);

    valid_in = 1'b1;
    alu_op = 3'b100;
    func = 6'b011011;
    flush = 1'b1;
    cyc();
    flush = 1'b0;
    valid_in = 1'b0;
    chk("flush md_start", md_start, 0);
    chk("flush ctr_valid", ctr_valid, 0);
    chk("flush md_busy", md_busy, 0);
    chk("flush alu_ctr", alu_ctr, 2);
    chk("flush md_sel", md_sel, 0);

    issue(3'b100, 6'b011010, 2, 1'b0, 2'b00);
    cyc();
    take("div3");
    valid_in = 1'b0;
    snap();
    repeat (5) cyc();
    chk("pre-rst busy", md_busy, 1);
    #2 rst = 1'b1;
    #1;
    chk("async rst md_busy", md_busy, 0);
    chk("async rst md_sel", md_sel, 0);
    chk("async rst ctr_valid", ctr_valid, 0);
    chk("async rst alu_ctr", alu_ctr, 2);
    cyc();
    rst = 1'b0;
    repeat (40) cyc();
    chk("no hilo_we after rst", we_n - w0, 0);
    chk("idle after rst", md_busy, 0);
    $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
    $finish;
  end
endmodule
